// File: rtl/reg_scoreboard.sv
// Register-pending scoreboard: one saturating-by-construction pending-write counter per register,
// raising stall on read-after-write hazards or counter exhaustion, and a sticky underflow flag.
module reg_scoreboard (
    input  logic       clk,
    input  logic       rst,
    input  logic       issue,
    input  logic       issue_wr,
    input  logic [2:0] issue_dst,
    input  logic       src1_used,
    input  logic [2:0] src1_sel,
    input  logic       src2_used,
    input  logic [2:0] src2_sel,
    input  logic       retire,
    input  logic [2:0] retire_dst,
    output logic       stall,
    output logic [7:0] busy,
    output logic       err
);

    logic [1:0] cnt [8];
    logic [7:0] inc;
    logic [7:0] dec;
    logic       accept;

    // Hazards are judged on the current counts only; there is no write-to-read bypass,
    // so a retire this cycle clears the hazard one cycle later.
    always_comb begin
        busy = 8'h00;
        for (int r = 0; r < 8; r++) begin
            busy[r] = (cnt[r] != 2'd0);
        end
        stall = issue & ((src1_used & busy[src1_sel]) |
                         (src2_used & busy[src2_sel]) |
                         (issue_wr & (cnt[issue_dst] == 2'd3)));
        accept = issue & ~stall;
        inc = 8'h00;
        dec = 8'h00;
        for (int r = 0; r < 8; r++) begin
            inc[r] = accept & issue_wr & (issue_dst == 3'(r));
            dec[r] = retire & (retire_dst == 3'(r)) & (cnt[r] != 2'd0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < 8; r++) begin
                cnt[r] <= 2'd0;
            end
            err <= 1'b0;
        end else begin
            for (int r = 0; r < 8; r++) begin
                if (inc[r] && !dec[r]) begin
                    cnt[r] <= cnt[r] + 2'd1;
                end else if (dec[r] && !inc[r]) begin
                    cnt[r] <= cnt[r] - 2'd1;
                end
            end
            // A retire to a register with nothing pending is a protocol error.
            if (retire && (cnt[retire_dst] == 2'd0)) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed self-checking bench for reg_scoreboard; expected values are hand-computed per step.
module tb_reg_scoreboard;

    logic       clk;
    logic       rst;
    logic       issue;
    logic       issue_wr;
    logic [2:0] issue_dst;
    logic       src1_used;
    logic [2:0] src1_sel;
    logic       src2_used;
    logic [2:0] src2_sel;
    logic       retire;
    logic [2:0] retire_dst;
    logic       stall;
    logic [7:0] busy;
    logic       err;

    int tests_run = 0;
    int tests_failed = 0;

    reg_scoreboard dut (
        .clk        (clk),
        .rst        (rst),
        .issue      (issue),
        .issue_wr   (issue_wr),
        .issue_dst  (issue_dst),
        .src1_used  (src1_used),
        .src1_sel   (src1_sel),
        .src2_used  (src2_used),
        .src2_sel   (src2_sel),
        .retire     (retire),
        .retire_dst (retire_dst),
        .stall      (stall),
        .busy       (busy),
        .err        (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic i, input logic w, input logic [2:0] d,
                                 input logic u1, input logic [2:0] s1,
                                 input logic u2, input logic [2:0] s2,
                                 input logic r, input logic [2:0] rd);
        issue      = i;
        issue_wr   = w;
        issue_dst  = d;
        src1_used  = u1;
        src1_sel   = s1;
        src2_used  = u2;
        src2_sel   = s2;
        retire     = r;
        retire_dst = rd;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        applyStimulus(0, 0, 3'd0, 0, 3'd0, 0, 3'd0, 0, 3'd0);
    endtask

    task automatic issueWrite(input logic [2:0] d);
        applyStimulus(1, 1, d, 0, 3'd0, 0, 3'd0, 0, 3'd0);
    endtask

    task automatic retireReg(input logic [2:0] d);
        applyStimulus(0, 0, 3'd0, 0, 3'd0, 0, 3'd0, 1, d);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        tick();
        rst = 1'b0;
        idle();
        checkOutput("reset_busy", 32'(busy), 32'h00);
        checkOutput("reset_err", 32'(err), 32'h0);
        checkOutput("reset_stall", 32'(stall), 32'h0);

        // Basic write then retire
        issueWrite(3'd2);
        checkOutput("w2_stall", 32'(stall), 32'h0);
        tick();
        checkOutput("w2_busy", 32'(busy), 32'h04);
        retireReg(3'd2);
        tick();
        checkOutput("r2_busy", 32'(busy), 32'h00);

        // RAW hazard; same-cycle retire does not bypass
        issueWrite(3'd2);
        tick();
        checkOutput("raw_setup", 32'(busy), 32'h04);
        applyStimulus(1, 1, 3'd7, 1, 3'd2, 0, 3'd0, 1, 3'd2);
        checkOutput("raw_stall_retire", 32'(stall), 32'h1);
        tick();
        checkOutput("raw_not_accepted", 32'(busy), 32'h00);
        applyStimulus(1, 1, 3'd7, 1, 3'd2, 0, 3'd0, 0, 3'd0);
        checkOutput("raw_stall_drop", 32'(stall), 32'h0);
        tick();
        checkOutput("raw_accepted", 32'(busy), 32'h80);
        retireReg(3'd7);
        tick();
        checkOutput("raw_clear", 32'(busy), 32'h00);

        // src2 hazard, and unused sources do not stall
        issueWrite(3'd2);
        tick();
        applyStimulus(1, 0, 3'd0, 0, 3'd0, 1, 3'd2, 0, 3'd0);
        checkOutput("src2_stall", 32'(stall), 32'h1);
        applyStimulus(1, 0, 3'd0, 0, 3'd2, 0, 3'd2, 0, 3'd0);
        checkOutput("unused_src_stall", 32'(stall), 32'h0);
        tick();
        checkOutput("nowrite_busy", 32'(busy), 32'h04);

        // issue=0 ignores everything else
        applyStimulus(0, 1, 3'd2, 1, 3'd2, 1, 3'd2, 0, 3'd0);
        checkOutput("noissue_stall", 32'(stall), 32'h0);
        tick();
        checkOutput("noissue_busy", 32'(busy), 32'h04);
        retireReg(3'd2);
        tick();
        checkOutput("noissue_cnt1", 32'(busy), 32'h00);

        // r3 <- r3 + r1 with both idle
        applyStimulus(1, 1, 3'd3, 1, 3'd3, 1, 3'd1, 0, 3'd0);
        checkOutput("self_src_stall", 32'(stall), 32'h0);
        tick();
        checkOutput("self_src_busy", 32'(busy), 32'h08);
        retireReg(3'd3);
        tick();
        checkOutput("self_src_clear", 32'(busy), 32'h00);

        // Counter full at 3
        for (int k = 0; k < 3; k++) begin
            issueWrite(3'd5);
            tick();
        end
        checkOutput("full_busy", 32'(busy), 32'h20);
        applyStimulus(1, 1, 3'd5, 0, 3'd0, 0, 3'd0, 1, 3'd5);
        checkOutput("full_stall", 32'(stall), 32'h1);
        tick();
        issueWrite(3'd5);
        checkOutput("fourth_accept", 32'(stall), 32'h0);
        tick();
        issueWrite(3'd5);
        checkOutput("refull_stall", 32'(stall), 32'h1);
        retireReg(3'd5);
        tick();
        checkOutput("full_ret1", 32'(busy), 32'h20);
        retireReg(3'd5);
        tick();
        checkOutput("full_ret2", 32'(busy), 32'h20);
        retireReg(3'd5);
        tick();
        checkOutput("full_ret3", 32'(busy), 32'h00);
        checkOutput("full_err", 32'(err), 32'h0);

        // Simultaneous inc and dec on r4
        issueWrite(3'd4);
        tick();
        applyStimulus(1, 1, 3'd4, 0, 3'd0, 0, 3'd0, 1, 3'd4);
        checkOutput("incdec_stall", 32'(stall), 32'h0);
        tick();
        checkOutput("incdec_busy", 32'(busy), 32'h10);
        retireReg(3'd4);
        tick();
        checkOutput("incdec_clear", 32'(busy), 32'h00);
        checkOutput("incdec_err", 32'(err), 32'h0);

        // Underflow sets sticky err without wrapping the counter
        retireReg(3'd6);
        tick();
        checkOutput("uf_err", 32'(err), 32'h1);
        checkOutput("uf_busy", 32'(busy), 32'h00);
        idle();
        tick();
        checkOutput("uf_sticky", 32'(err), 32'h1);
        issueWrite(3'd6);
        tick();
        checkOutput("uf_nowrap", 32'(busy), 32'h40);
        retireReg(3'd6);
        tick();
        checkOutput("uf_nowrap_clear", 32'(busy), 32'h00);
        checkOutput("uf_still_err", 32'(err), 32'h1);
        rst = 1'b1;
        idle();
        tick();
        rst = 1'b0;
        checkOutput("uf_rst_err", 32'(err), 32'h0);

        // Reset mid-operation with issue and retire asserted
        issueWrite(3'd0); tick();
        issueWrite(3'd2); tick();
        issueWrite(3'd5); tick();
        issueWrite(3'd7); tick();
        checkOutput("a5_busy", 32'(busy), 32'hA5);
        retireReg(3'd3);
        tick();
        checkOutput("a5_err", 32'(err), 32'h1);
        rst = 1'b1;
        applyStimulus(1, 1, 3'd1, 0, 3'd0, 0, 3'd0, 1, 3'd0);
        tick();
        rst = 1'b0;
        idle();
        checkOutput("rst_busy", 32'(busy), 32'h00);
        checkOutput("rst_err", 32'(err), 32'h0);
        checkOutput("rst_stall", 32'(stall), 32'h0);
        tick();
        checkOutput("rst_no_issue", 32'(busy), 32'h00);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/reg_scoreboard.md
REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port: issue  input  1  decode stage presents an instruction this cycle.
REQ-004 SHALL have port: issue_wr  input  1  presented instruction writes a register.
REQ-005 SHALL have port: issue_dst  input  3  destination register of presented instruction.
REQ-006 SHALL have port: src1_used  input  1  presented instruction reads src1_sel.
REQ-007 SHALL have port: src1_sel  input  3  first source register (drives register file read1regsel).
REQ-008 SHALL have port: src2_used  input  1  presented instruction reads src2_sel.
REQ-009 SHALL have port: src2_sel  input  3  second source register (drives register file read2regsel).
REQ-010 SHALL have port: retire  input  1  writeback writes the register file this cycle (same as register file write).
REQ-011 SHALL have port: retire_dst  input  3  register written by writeback (same as register file writeregsel).
REQ-012 SHALL have port: stall  output  1  presented instruction must be held in decode.
REQ-013 SHALL have port: busy  output  8  bit r set when register r has a pending write.
REQ-014 SHALL have port: err  output  1  sticky protocol-error flag.

Function
REQ-015 SHALL hold one 2-bit pending-write counter per register, cnt[0..7], range 0..3.
REQ-016 SHALL drive busy[r] = (cnt[r] != 0), combinational from registered state only.
REQ-017 SHALL drive stall combinationally = issue & ((src1_used & busy[src1_sel]) | (src2_used & busy[src2_sel]) | (issue_wr & cnt[issue_dst]==3)).
REQ-018 SHALL evaluate stall from current-cycle cnt: a retire to a source register in the same cycle does NOT clear stall that cycle (register file has no write-to-read bypass); stall drops the following cycle.
REQ-019 SHALL define accept = issue & ~stall; inc[r] = accept & issue_wr & (issue_dst==r).
REQ-020 SHALL define dec[r] = retire & (retire_dst==r) & (cnt[r]!=0).
REQ-021 SHALL update each cycle: cnt[r] <= cnt[r] + inc[r] - dec[r]; inc and dec on the same register in the same cycle leave cnt unchanged.
REQ-022 SHALL never wrap cnt: increment beyond 3 is impossible because stall blocks it (REQ-017); decrement below 0 is suppressed (REQ-020).
REQ-023 SHALL set err on the next edge when retire is asserted with cnt[retire_dst]==0 (underflow); err stays 1 until rst.
REQ-024 SHALL ignore issue_wr, issue_dst, src*_used and src*_sel when issue=0 (stall=0, no increment).
REQ-025 SHALL allow an instruction whose source equals its own destination (e.g. r3 <- r3+r1) to issue when cnt[3]==0 and cnt[1]==0; its own increment does not stall itself.
REQ-026 SHALL accept at most one issue and one retire per cycle; latency from retire edge to busy clear is one cycle.

Reset
REQ-027 SHALL, on rst=1 at a rising edge, clear all cnt to 0 and err to 0, giving busy=8'h00 and stall=0 the following cycle.
REQ-028 SHALL give rst priority over simultaneous issue or retire; neither is counted in the reset cycle.
REQ-029 SHALL discard all pending counts when rst is asserted mid-operation; no counter state survives reset.

Verification
REQ-030 SHALL cover: after reset, issue write r2 (no sources) -> stall=0, next cycle busy=8'h04; retire r2 -> busy=8'h00 one cycle later.
REQ-031 SHALL cover: busy[2]=1, issue with src1_used=1, src1_sel=2 -> stall=1; retire r2 in that cycle -> stall still 1, stall=0 next cycle, and the instruction is accepted.
REQ-032 SHALL cover: three accepted writes to r5 -> cnt[5]=3; fourth issue_wr to r5 -> stall=1, cnt stays 3; one retire r5 -> fourth issue accepted next cycle.
REQ-033 SHALL cover: cnt[4]=1, accepted issue_wr r4 and retire r4 in the same cycle -> cnt[4]=1, busy[4]=1 afterward.
REQ-034 SHALL cover: retire r6 with cnt[6]=0 -> err=1 next cycle, cnt[6] stays 0; err held until rst, then err=0.
REQ-035 SHALL cover: rst asserted with busy=8'hA5 and issue asserted -> busy=8'h00, err=0, stall=0 after the edge.
